// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: MULT/DIV sequencer states and register constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // MULT/DIV sequencer: IDLE (no op), BUSY (counting down), DONE (HI/LO write cycle).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // $zero is hard-wired; a load targeting it never creates a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_md_seq.sv
// MULT/DIV sequencer: tracks an in-flight HI/LO operation and strobes its completion.
// Latency: start seen in cycle t -> BUSY for N cycles -> md_done_o in cycle t+N+1 (N = MUL/DIV_CYCLES).
// Backpressure: none; a start while BUSY is ignored, an op in flight always runs to completion.
// Ports:
//   clk, rst_n      clock, async active-low reset (abandons any op in flight)
//   md_start_i      EX holds a valid MULT/DIV this cycle
//   md_div_i        1 = divide latency, 0 = multiply latency
//   md_busy_o       registered, high whenever state_o != IDLE
//   md_done_o       registered, high exactly in the DONE cycle
//   state_o         current sequencer state
module md_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      md_start_i,
  input  logic      md_div_i,
  output logic      md_busy_o,
  output logic      md_done_o,
  output md_state_t state_o
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] load_d;
  logic             busy_q;
  logic             done_q;

  // Counter loads N-1 so that BUSY lasts exactly N cycles (N..1 remaining -> 0).
  assign load_d = md_div_i ? DIV_LOAD : MUL_LOAD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_start_i) begin
            state_q <= BUSY;
            cnt_q   <= load_d;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          done_q <= 1'b0;
          // Back-to-back op: the next one may start in the write-back cycle.
          if (md_start_i) begin
            state_q <= BUSY;
            cnt_q   <= load_d;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign md_busy_o = busy_q;
  assign md_done_o = done_q;
  assign state_o   = state_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, HI/LO-pending holds, stall counter.
// Latency: control outputs are combinational from inputs and registered MD state (same cycle).
// Backpressure: stalls drop pc_en/ifid_en and bubble ID/EX; a taken branch overrides any stall.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   id_* / ex_*                        ID and EX stage observation inputs
//   pc_en, ifid_en, ifid_clr, idex_clr pipeline register controls
//   md_busy, md_done                   MULT/DIV in flight / one-cycle HI/LO write strobe
//   stall_cycles                       wrapping count of cycles with pc_en low out of reset
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_md_op,
  input  logic        id_reads_hilo,
  input  logic        ex_valid,
  input  logic        ex_mem_to_reg,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_wb_reg,
  input  logic        ex_md_op,
  input  logic        ex_md_div,
  input  logic        ex_branch_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_clr,
  output logic        idex_clr,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles
);

  md_state_t   md_state;
  logic        md_start;
  logic        load_use;
  logic        md_hold;
  logic [31:0] stall_q;

  assign md_start = ex_valid & ex_md_op;

  assign load_use = id_valid & ex_valid & ex_mem_to_reg & ex_reg_write &
                    (ex_wb_reg != REG_ZERO) &
                    ((id_use_rs & (id_rs == ex_wb_reg)) |
                     (id_use_rt & (id_rt == ex_wb_reg)));

  // HI/LO consumers wait while an op is in flight, including the DONE cycle, so
  // they are released only once HI/LO has been written. A start this cycle counts too.
  assign md_hold = id_valid & (id_md_op | id_reads_hilo) &
                   ((md_state != IDLE) | md_start);

  md_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .md_start_i (md_start),
    .md_div_i   (ex_md_div),
    .md_busy_o  (md_busy),
    .md_done_o  (md_done),
    .state_o    (md_state)
  );

  always_comb begin
    pc_en    = 1'b1;
    ifid_en  = 1'b1;
    ifid_clr = 1'b0;
    idex_clr = 1'b0;
    if (!rst_n) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if (ex_branch_taken) begin
      // Redirect wins: wrong-path IF/ID and ID/EX contents are discarded anyway.
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if (load_use | md_hold) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (!pc_en) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: vector table, hand-written MULT/DIV/reset sequences, random run.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;

  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_md_op;
    logic       id_reads_hilo;
    logic       ex_valid;
    logic       ex_mem_to_reg;
    logic       ex_reg_write;
    logic [4:0] ex_wb_reg;
    logic       ex_md_op;
    logic       ex_md_div;
    logic       ex_branch_taken;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [3:0] exp; // {pc_en, ifid_en, ifid_clr, idex_clr}
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_rs, id_use_rt, id_md_op, id_reads_hilo;
  logic [4:0]  id_rs, id_rt, ex_wb_reg;
  logic        ex_valid, ex_mem_to_reg, ex_reg_write, ex_md_op, ex_md_div, ex_branch_taken;
  logic        pc_en, ifid_en, ifid_clr, idex_clr, md_busy, md_done;
  logic [31:0] stall_cycles;
  logic [3:0]  ctrl;

  assign ctrl = {pc_en, ifid_en, ifid_clr, idex_clr};

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_md_op        (id_md_op),
    .id_reads_hilo   (id_reads_hilo),
    .ex_valid        (ex_valid),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .ex_reg_write    (ex_reg_write),
    .ex_wb_reg       (ex_wb_reg),
    .ex_md_op        (ex_md_op),
    .ex_md_div       (ex_md_div),
    .ex_branch_taken (ex_branch_taken),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_clr        (ifid_clr),
    .idex_clr        (idex_clr),
    .md_busy         (md_busy),
    .md_done         (md_done),
    .stall_cycles    (stall_cycles)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: absolute cycle numbers of the last MD start and its write-back.
  int          cyc     = 0;
  int          st_cyc  = -1;
  int          done_at = -1;
  logic [31:0] stall_exp = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_busy();
    return (cyc > st_cyc) && (cyc <= done_at);
  endfunction

  function automatic logic [3:0] m_ctrl(input in_t v);
    logic lu, hold;
    lu = v.id_valid && v.ex_valid && v.ex_mem_to_reg && v.ex_reg_write && (v.ex_wb_reg != 5'd0) &&
         ((v.id_use_rs && v.id_rs == v.ex_wb_reg) || (v.id_use_rt && v.id_rt == v.ex_wb_reg));
    hold = v.id_valid && (v.id_md_op || v.id_reads_hilo) && (m_busy() || (v.ex_valid && v.ex_md_op));
    if (v.ex_branch_taken) return 4'b1111;
    if (lu || hold)        return 4'b0001;
    return 4'b1100;
  endfunction

  task automatic model_reset();
    st_cyc    = -1;
    done_at   = -1;
    stall_exp = '0;
  endtask

  task automatic apply(input in_t v);
    id_valid        = v.id_valid;
    id_rs           = v.id_rs;
    id_rt           = v.id_rt;
    id_use_rs       = v.id_use_rs;
    id_use_rt       = v.id_use_rt;
    id_md_op        = v.id_md_op;
    id_reads_hilo   = v.id_reads_hilo;
    ex_valid        = v.ex_valid;
    ex_mem_to_reg   = v.ex_mem_to_reg;
    ex_reg_write    = v.ex_reg_write;
    ex_wb_reg       = v.ex_wb_reg;
    ex_md_op        = v.ex_md_op;
    ex_md_div       = v.ex_md_div;
    ex_branch_taken = v.ex_branch_taken;
  endtask

  // Called at a negedge: drive, settle, compare against the model, advance the model by one cycle.
  task automatic drive_chk(input in_t v);
    logic [3:0] e;
    apply(v);
    #1;
    e = m_ctrl(v);
    chk("ctrl", 32'(ctrl), 32'(e));
    chk("md_busy", 32'(md_busy), 32'(m_busy()));
    chk("md_done", 32'(md_done), 32'(cyc == done_at));
    chk("stall_cycles", stall_cycles, stall_exp);
    if (!e[3]) stall_exp = stall_exp + 32'd1;
    if (v.ex_valid && v.ex_md_op) begin
      st_cyc  = cyc;
      done_at = cyc + (v.ex_md_div ? DIV_N : MUL_N) + 1;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic in_t ld(input logic [4:0] wb, input logic [4:0] rs, input logic urs,
                             input logic [4:0] rt, input logic urt);
    in_t v = '0;
    v.id_valid = 1'b1; v.ex_valid = 1'b1; v.ex_mem_to_reg = 1'b1; v.ex_reg_write = 1'b1;
    v.ex_wb_reg = wb; v.id_rs = rs; v.id_use_rs = urs; v.id_rt = rt; v.id_use_rt = urt;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[13];
    in_t  nop, mult, divv, mflo, brn, v;
    int   done_i, rel_i, sd;
    logic [31:0] s0;

    nop  = '0;
    mult = '0; mult.ex_valid = 1'b1; mult.ex_md_op = 1'b1;
    divv = mult; divv.ex_md_div = 1'b1;
    mflo = '0; mflo.id_valid = 1'b1; mflo.id_reads_hilo = 1'b1;
    brn  = '0; brn.ex_branch_taken = 1'b1;

    tab[0].in  = ld(5'd2, 5'd2, 1'b1, 5'd3, 1'b1); tab[0].exp  = 4'b0001; // lw $2; add reads $2
    tab[1].in  = ld(5'd2, 5'd4, 1'b1, 5'd3, 1'b1); tab[1].exp  = 4'b1100; // next instr independent
    tab[2].in  = ld(5'd0, 5'd0, 1'b1, 5'd0, 1'b1); tab[2].exp  = 4'b1100; // load to $0
    tab[3].in  = ld(5'd5, 5'd1, 1'b1, 5'd5, 1'b0); tab[3].exp  = 4'b1100; // rt matches but unused
    tab[4].in  = ld(5'd5, 5'd1, 1'b1, 5'd5, 1'b1); tab[4].exp  = 4'b0001; // rt match used
    tab[5].in  = ld(5'd2, 5'd2, 1'b1, 5'd3, 1'b1); tab[5].in.ex_branch_taken = 1'b1;
    tab[5].exp = 4'b1111;                                                 // branch beats load-use
    tab[6].in  = ld(5'd7, 5'd7, 1'b1, 5'd0, 1'b0); tab[6].in.ex_valid = 1'b0;      tab[6].exp = 4'b1100;
    tab[7].in  = ld(5'd7, 5'd7, 1'b1, 5'd0, 1'b0); tab[7].in.id_valid = 1'b0;      tab[7].exp = 4'b1100;
    tab[8].in  = ld(5'd7, 5'd7, 1'b1, 5'd0, 1'b0); tab[8].in.ex_reg_write = 1'b0;  tab[8].exp = 4'b1100;
    tab[9].in  = ld(5'd7, 5'd7, 1'b1, 5'd0, 1'b0); tab[9].in.ex_mem_to_reg = 1'b0; tab[9].exp = 4'b1100;
    tab[10].in = brn;  tab[10].exp = 4'b1111;
    tab[11].in = mflo; tab[11].exp = 4'b1100;                             // MD idle: MFLO flows
    tab[12].in = mflo; tab[12].in.ex_valid = 1'b1; tab[12].in.ex_md_op = 1'b1;
    tab[12].exp = 4'b0001;                                                // MULT starting this cycle

    // Reset state
    rst_n = 1'b0;
    apply(nop);
    @(negedge clk);
    #1;
    chk("rst_ctrl", 32'(ctrl), 32'(4'b0011));
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_done", 32'(md_done), 32'd0);
    chk("rst_stall", stall_cycles, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Vector table
    for (int i = 0; i < 13; i++) begin
      drive_chk(tab[i].in);
      chk($sformatf("vec%0d", i), 32'(ctrl), 32'(tab[i].exp));
      tick();
    end
    for (int i = 0; i < 8; i++) begin drive_chk(nop); tick(); end

    // MULT then MFLO: BUSY for 4 cycles, DONE at +5, MFLO released at +6 after 5 stall cycles
    drive_chk(mult);
    s0 = stall_cycles;
    tick();
    done_i = -1; rel_i = -1; sd = -1;
    for (int i = 1; i <= 40 && rel_i < 0; i++) begin
      drive_chk(mflo);
      if (md_done && done_i < 0) done_i = i;
      if (pc_en) begin rel_i = i; sd = int'(stall_cycles - s0); end
      tick();
    end
    chk("mult_done_offset", 32'(done_i), 32'd5);
    chk("mflo_release_offset", 32'(rel_i), 32'd6);
    chk("mult_stall_count", 32'(sd), 32'd5);
    for (int i = 0; i < 4; i++) begin drive_chk(nop); tick(); end

    // DIV with a taken branch 3 cycles later: flush happens, op keeps running
    drive_chk(divv); tick();
    for (int i = 1; i <= 2; i++) begin drive_chk(nop); tick(); end
    drive_chk(brn);
    chk("div_branch_flush", 32'(ctrl), 32'(4'b1111));
    chk("div_busy_at_flush", 32'(md_busy), 32'd1);
    tick();
    done_i = -1;
    for (int i = 4; i <= 80 && done_i < 0; i++) begin
      drive_chk(nop);
      if (md_done) done_i = i;
      tick();
    end
    chk("div_done_offset", 32'(done_i), 32'd33);
    for (int i = 0; i < 4; i++) begin drive_chk(nop); tick(); end

    // Reset during BUSY abandons the op
    drive_chk(mult); tick();
    drive_chk(mflo); tick();
    drive_chk(mflo); tick();
    rst_n = 1'b0;
    apply(mult);
    #1;
    chk("midrst_ctrl", 32'(ctrl), 32'(4'b0011));
    chk("midrst_busy", 32'(md_busy), 32'd0);
    chk("midrst_done", 32'(md_done), 32'd0);
    chk("midrst_stall", stall_cycles, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("midrst_held_busy", 32'(md_busy), 32'd0);
    chk("midrst_held_ctrl", 32'(ctrl), 32'(4'b0011));
    @(negedge clk);
    apply(nop);
    rst_n = 1'b1;
    model_reset();
    drive_chk(nop);
    chk("stall_after_rst", stall_cycles, 32'd0);
    tick();
    for (int i = 0; i < 40; i++) begin
      drive_chk(mflo);
      chk("no_done_after_rst", 32'(md_done), 32'd0);
      tick();
    end

    // Random run against the model; MD starts only when the sequencer can accept them
    for (int n = 0; n < 400; n++) begin
      v = '0;
      v.id_valid        = ($urandom % 4) != 0;
      v.id_rs           = 5'($urandom_range(0, 3));
      v.id_rt           = 5'($urandom_range(0, 3));
      v.id_use_rs       = $urandom % 2;
      v.id_use_rt       = $urandom % 2;
      v.id_md_op        = ($urandom % 6) == 0;
      v.id_reads_hilo   = ($urandom % 5) == 0;
      v.ex_valid        = ($urandom % 4) != 0;
      v.ex_mem_to_reg   = ($urandom % 3) == 0;
      v.ex_reg_write    = ($urandom % 4) != 0;
      v.ex_wb_reg       = 5'($urandom_range(0, 3));
      v.ex_md_op        = (!m_busy() || cyc == done_at) && (($urandom % 8) == 0);
      v.ex_md_div       = ($urandom % 5) == 0;
      v.ex_branch_taken = ($urandom % 10) == 0;
      drive_chk(v);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
